smix_scratchpad_ctrl: RTL
=========================

// Module: smix_scratchpad_ctrl
// PURPOSE
//  Parametrised SMIX scratchpad: stores DEPTH blocks of BLOCK_BITS in a single-port sync SRAM
//  of BEAT_BITS-wide words, moving each block as BEATS=BLOCK_BITS/BEAT_BITS sequential beats.
//  Adds valid/ready request and response handshakes, a registered read path and an
//  auto-increment fill pointer for the SMIX V[i] write loop. Sits between the SMIX core and
//  on-chip SRAM, replacing the fixed 1024-bit combinational scratchpad.
// PARAMETERS
//  BLOCK_BITS  1024  bits per scratchpad block (one SMIX X value)
//  BEAT_BITS   256   SRAM word width; BLOCK_BITS % BEAT_BITS == 0 (elaboration error otherwise)
//  DEPTH       1024  blocks stored; power of two >= 2 (elaboration error otherwise)
//  ADDR_BITS   $clog2(DEPTH)  block address width (derived)
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  n_rst      in   1           asynchronous active-low reset
//  req_valid  in   1           request present
//  req_ready  out  1           controller can accept a request
//  req_write  in   1           1 = write block, 0 = read block
//  req_auto   in   1           write only: use fill_ptr instead of req_addr
//  req_addr   in   ADDR_BITS   block address
//  req_wdata  in   BLOCK_BITS  write block; beat b = req_wdata[b*BEAT_BITS +: BEAT_BITS]
//  rsp_valid  out  1           read block available on rsp_rdata
//  rsp_ready  in   1           consumer accepts read block
//  rsp_rdata  out  BLOCK_BITS  assembled read block
//  wr_done    out  1           one-cycle pulse: write finished
//  ptr_clr    in   1           synchronous clear of fill_ptr and full
//  fill_ptr   out  ADDR_BITS   next auto-write block address
//  full       out  1           all DEPTH blocks written since last clear
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, wr_done=0, fill_ptr=0, full=0.
//   Memory contents are not reset. Reset mid-operation aborts it; no partial response.
//  FSM: IDLE -> WRITE | READ on accept (req_valid & req_ready); WRITE -> IDLE after last beat;
//   READ -> RESP after last beat; RESP -> IDLE when rsp_ready.
//  req_ready = (state==IDLE), combinational from state only; no combinational path from
//   req_valid to req_ready.
//  On accept, latch write flag, effective address and wdata; beat counter = 0.
//  Effective write addr = req_auto ? fill_ptr : req_addr. Reads always use req_addr
//   (req_auto ignored).
//  SRAM word index = {addr, beat}; beat b of block a at word a*BEATS+b.
//  WRITE: one beat per cycle, beats 0..BEATS-1 in cycles T+1..T+BEATS (accept = cycle T);
//   wr_done=1 in cycle T+BEATS+1, same cycle req_ready returns high.
//  READ: beat b read address issued cycle T+1+b; data lands in rsp_rdata slice b at end of
//   that cycle. rsp_valid=1 from cycle T+BEATS+1; rsp_rdata stable while rsp_valid.
//  RESP: rsp_valid and rsp_rdata hold until rsp_valid&rsp_ready; rsp_valid=0 and
//   req_ready=1 the next cycle. No new request accepted while in RESP.
//  Back-to-back throughput: write BEATS+1 cycles; read >= BEATS+2 cycles.
//  fill_ptr: increments by 1 (mod DEPTH) at accept of an auto write. On wrap DEPTH-1 -> 0,
//   full sets and stays set (further auto writes overwrite from 0) until ptr_clr or reset.
//  ptr_clr: fill_ptr=0, full=0 next cycle. Priority over an auto-write increment in the same
//   cycle. An in-flight write keeps its latched address.
//  req_addr/req_wdata are sampled only at accept and may change afterwards.
// TESTING
//  1 Reset: drive n_rst=0 mid-READ -> next cycle req_ready=1, rsp_valid=0, fill_ptr=0, full=0.
//  2 Write addr 5, data {4 beats 0xA..,0xB..,0xC..,0xD..}, then read 5 (BEATS=4).
//    -> wr_done at T+5; rsp_valid at T+5 after the read accept; rsp_rdata == written block.
//  3 Hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout;
//    raise rsp_ready -> req_ready=1 next cycle.
//  4 DEPTH=4: 4 auto writes -> fill_ptr 1,2,3,0, full=1 after 4th accept; 5th overwrites
//    block 0; ptr_clr + auto write same cycle -> fill_ptr=0, full=0.
//  5 Write blocks 0 and DEPTH-1 with distinct patterns, read both -> no aliasing of beats
//    across blocks; the read-back beat order matches req_wdata slices.
//  6 Random mixed read/write traffic vs reference model; request-field changes after accept
//    have no effect.

Source files
------------

// File: rtl/smix_scratchpad_ctrl.sv
// SMIX scratchpad controller: DEPTH blocks held in a single-port synchronous SRAM of
// BEAT_BITS-wide words, each block moved as BEATS sequential beats behind valid/ready handshakes.
module smix_scratchpad_ctrl #(
    parameter int  BLOCK_BITS = 1024,
    parameter int  BEAT_BITS  = 256,
    parameter int  DEPTH      = 1024,
    localparam int ADDR_BITS  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_auto,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [BLOCK_BITS-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BLOCK_BITS-1:0] rsp_rdata,
    output logic                  wr_done,
    input  logic                  ptr_clr,
    output logic [ADDR_BITS-1:0]  fill_ptr,
    output logic                  full
);

    localparam int BEATS  = BLOCK_BITS / BEAT_BITS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORDS  = DEPTH * BEATS;
    localparam int WORD_W = ADDR_BITS + BEAT_W;
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    if ((BEATS < 1) || ((BLOCK_BITS % BEAT_BITS) != 0)) begin : g_bad_beat
        $error("smix_scratchpad_ctrl: BLOCK_BITS must be a multiple of BEAT_BITS");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("smix_scratchpad_ctrl: DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } state_t;

    state_t                          r_state;
    logic [BEAT_BITS-1:0]            r_mem [WORDS];
    logic [BEATS-1:0][BEAT_BITS-1:0] r_wdata;
    logic [BEATS-1:0][BEAT_BITS-1:0] r_rdata;
    logic [ADDR_BITS-1:0]            r_addr;
    logic [BEAT_W-1:0]               r_beat;
    logic                            r_rspValid;
    logic                            r_wrDone;
    logic [ADDR_BITS-1:0]            r_fillPtr;
    logic                            r_full;
    logic                            w_accept;
    logic                            w_autoAccept;
    logic [WORD_W-1:0]               w_wordIdx;

    assign req_ready    = (r_state == ST_IDLE);
    assign w_accept     = req_valid && (r_state == ST_IDLE);
    assign w_autoAccept = w_accept && req_write && req_auto;
    assign w_wordIdx    = WORD_W'(r_addr) * WORD_W'(BEATS) + WORD_W'(r_beat);

    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rdata;
    assign wr_done   = r_wrDone;
    assign fill_ptr  = r_fillPtr;
    assign full      = r_full;

    // Memory contents are deliberately not reset; only the write port lives here.
    always_ff @(posedge clk) begin
        if (r_state == ST_WRITE) begin
            r_mem[w_wordIdx] <= r_wdata[r_beat];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_beat     <= '0;
            r_rspValid <= 1'b0;
            r_wrDone   <= 1'b0;
            r_fillPtr  <= '0;
            r_full     <= 1'b0;
        end else begin
            r_wrDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= (req_write && req_auto) ? r_fillPtr : req_addr;
                        r_wdata <= req_wdata;
                        r_beat  <= '0;
                        r_state <= req_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (r_beat == LAST_BEAT) begin
                        r_state  <= ST_IDLE;
                        r_wrDone <= 1'b1;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                ST_READ: begin
                    // The synchronous SRAM read lands straight in the response slice.
                    r_rdata[r_beat] <= r_mem[w_wordIdx];
                    if (r_beat == LAST_BEAT) begin
                        r_state    <= ST_RESP;
                        r_rspValid <= 1'b1;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Clearing wins over an auto-write bump; the accepted write keeps its latched address.
            if (ptr_clr) begin
                r_fillPtr <= '0;
                r_full    <= 1'b0;
            end else if (w_autoAccept) begin
                r_fillPtr <= r_fillPtr + 1'b1;
                if (r_fillPtr == LAST_ADDR) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

endmodule
